// File: rtl/div_seq_if.sv
// Handshake and result bundle between the EX-stage sequencer and the iterative divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_cancel;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport master (
    output div_start, div_signed, div_a, div_b, div_cancel,
    input  div_stall, div_done, div_hi, div_lo
  );

  modport slave (
    input  div_start, div_signed, div_a, div_b, div_cancel,
    output div_stall, div_done, div_hi, div_lo
  );
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU: HI = remainder, LO = quotient.
// Optional macro DIV_EARLY_OUT_EN skips the iteration when |a| < |b| or b == 0.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sgn_reg;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             stall;
  logic             early;
  logic             accept;

  assign accept = bus.div_start && !bus.div_cancel;

  assign abs_a = (sgn_reg && a_reg[WIDTH-1]) ? ('0 - a_reg) : a_reg;
  assign abs_b = (sgn_reg && b_reg[WIDTH-1]) ? ('0 - b_reg) : b_reg;

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b) || (b_reg == '0);
`else
  assign early = 1'b0;
`endif

  // quo starts as |a| and is shifted out MSB-first while quotient bits shift in
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = PREP;
        end
      end
      PREP: begin
        if (bus.div_cancel) begin
          state_nx = IDLE;
        end else begin
          stall    = 1'b1;
          state_nx = early ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (bus.div_cancel) begin
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
          if (counter == CW'(WIDTH - 1)) begin
            state_nx = FIXUP;
          end
        end
      end
      FIXUP: begin
        if (bus.div_cancel) begin
          state_nx = IDLE;
        end else begin
          stall    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= bus.div_a;
            b_reg   <= bus.div_b;
            sgn_reg <= bus.div_signed;
          end
        end
        PREP: begin
          if (!bus.div_cancel) begin
            neg_q   <= sgn_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
            neg_r   <= sgn_reg && a_reg[WIDTH-1];
            dvs     <= abs_b;
            counter <= '0;
            if (early) begin
              quo <= '0;
              rem <= abs_a;
            end else begin
              quo <= abs_a;
              rem <= '0;
            end
          end
        end
        CALC: begin
          if (!bus.div_cancel) begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            counter <= counter + CW'(1);
          end
        end
        FIXUP: begin
          if (!bus.div_cancel) begin
            // zero divisor returns the raw dividend, never sign-corrected
            if (b_reg == '0) begin
              lo_r <= '1;
              hi_r <= a_reg;
            end else begin
              lo_r <= neg_q ? ('0 - quo) : quo;
              hi_r <= neg_r ? ('0 - rem) : rem;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.div_stall = stall;
  assign bus.div_done  = (state == DONE);
  assign bus.div_hi    = hi_r;
  assign bus.div_lo    = lo_r;

endmodule
